// File: rtl/demo_audio_pkg.sv
// Shared constants for the demo audio path: default sizing, full-scale envelope level
// and the looping note table (phase increments per clock).
package demo_audio_pkg;

    localparam int DEF_PHASE_W         = 16;
    localparam int DEF_AMP_W           = 8;
    localparam int DEF_STEPS           = 16;
    localparam int DEF_FRAMES_PER_STEP = 8;
    localparam int DEF_DECAY           = 16;

    localparam logic [DEF_AMP_W-1:0] AMP_MAX = {DEF_AMP_W{1'b1}};

    // Increment 0 marks a rest step.
    function automatic logic [DEF_PHASE_W-1:0] note_inc(input logic [3:0] idx);
        logic [DEF_PHASE_W-1:0] inc;
        case (idx)
            4'd0:    inc = 16'h0000;
            4'd1:    inc = 16'h0400;
            4'd2:    inc = 16'h0480;
            4'd3:    inc = 16'h0510;
            4'd4:    inc = 16'h0560;
            4'd5:    inc = 16'h0000;
            4'd6:    inc = 16'h0400;
            4'd7:    inc = 16'h0360;
            4'd8:    inc = 16'h0300;
            4'd9:    inc = 16'h0000;
            4'd10:   inc = 16'h0480;
            4'd11:   inc = 16'h0400;
            4'd12:   inc = 16'h0360;
            4'd13:   inc = 16'h0300;
            4'd14:   inc = 16'h0280;
            default: inc = 16'h0000;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry out of an AMP_W-bit accumulator is the
// 1-bit output, so ones density equals sample / 2^AMP_W.
module sigma_delta_dac
    import demo_audio_pkg::*;
#(
    parameter int AMP_W = DEF_AMP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [AMP_W-1:0] sample,
    output logic             bit_out
);

    logic [AMP_W-1:0] r_acc;
    logic             r_bit;
    logic [AMP_W:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, sample};
    assign bit_out = r_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_bit <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_bit <= 1'b0;
        end else begin
            r_acc <= w_sum[AMP_W-1:0];
            r_bit <= w_sum[AMP_W];
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Frame-locked note sequencer: steps a looping note table, runs a square-wave phase
// accumulator with a decaying envelope, and drives the 1-bit audio pin via sigma-delta.
module tone_sequencer
    import demo_audio_pkg::*;
#(
    parameter int PHASE_W         = DEF_PHASE_W,
    parameter int AMP_W           = DEF_AMP_W,
    parameter int STEPS           = DEF_STEPS,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int DECAY           = DEF_DECAY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic                     enable,
    output logic                     audio,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     note_on
);

    localparam int STEP_W = $clog2(STEPS);
    localparam int FC_W   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [AMP_W-1:0] DECAY_V   = AMP_W'(DECAY);
    // Note table and full-scale level are authored for the default widths.
    localparam logic [AMP_W-1:0] L_AMP_MAX = AMP_W'(AMP_MAX);

    logic [PHASE_W-1:0] r_phase;
    logic [AMP_W-1:0]   r_amp;
    logic [STEP_W-1:0]  r_step;
    logic [FC_W-1:0]    r_frame_cnt;
    logic               r_note_on;

    logic               w_advance;
    logic [STEP_W-1:0]  w_step_next;
    logic [PHASE_W-1:0] w_inc_cur;
    logic [PHASE_W-1:0] w_inc_next;
    logic [AMP_W-1:0]   w_amp_decayed;
    logic [AMP_W-1:0]   w_sample;
    logic               w_audio;

    assign w_advance     = frame_tick && (r_frame_cnt == FC_LAST);
    assign w_step_next   = r_step + STEP_W'(1);
    assign w_inc_cur     = PHASE_W'(note_inc(4'(r_step)));
    assign w_inc_next    = PHASE_W'(note_inc(4'(w_step_next)));
    assign w_amp_decayed = (r_amp > DECAY_V) ? (r_amp - DECAY_V) : '0;
    assign w_sample      = r_phase[PHASE_W-1] ? r_amp : '0;

    // A step advance retriggers the note and overrides both decay and phase advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= '0;
            r_amp       <= '0;
            r_step      <= '0;
            r_frame_cnt <= '0;
        end else if (enable) begin
            if (w_advance) begin
                r_frame_cnt <= '0;
                r_step      <= w_step_next;
                r_phase     <= '0;
                r_amp       <= (w_inc_next != '0) ? L_AMP_MAX : '0;
            end else begin
                r_phase <= r_phase + w_inc_cur;
                if (frame_tick) begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                    r_amp       <= w_amp_decayed;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note_on <= 1'b0;
        end else begin
            r_note_on <= (r_amp != '0);
        end
    end

    sigma_delta_dac #(
        .AMP_W (AMP_W)
    ) u_dac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (~enable),
        .sample  (w_sample),
        .bit_out (w_audio)
    );

    assign audio   = w_audio;
    assign step    = r_step;
    assign note_on = r_note_on;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: tempo, pitch, envelope, DAC density, rest,
// disable/resume and asynchronous reset, with hand-computed expectations.
module tb_tone_sequencer;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       frame_tick = 1'b0;
    logic       enable     = 1'b0;
    logic       audio;
    logic [3:0] step;
    logic       note_on;

    int total = 0;
    int bad   = 0;

    tone_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .enable     (enable),
        .audio      (audio),
        .step       (step),
        .note_on    (note_on)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc(2);
        end
    endtask

    task automatic wait_audio_high(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (audio === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int ones;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({audio, step, note_on} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got audio=%b step=%0d note_on=%b required 0/0/0", audio, step, note_on);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        ones   = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            ones += int'(audio);
        end
        total++;
        if (ones !== 0) begin
            bad++;
            $display("FAIL reset_silent_step0: got %0d ones required 0", ones);
        end
    endtask

    task automatic test_tempo();
        ticks(7);
        total++;
        if (step !== 4'd0) begin
            bad++;
            $display("FAIL tempo_before_8th: got step=%0d required 0", step);
        end
        tick();
        total++;
        if (step !== 4'd1) begin
            bad++;
            $display("FAIL tempo_8th_tick: got step=%0d required 1", step);
        end
        cyc(5);
        total++;
        if (step !== 4'd1) begin
            bad++;
            $display("FAIL tempo_hold_between: got step=%0d required 1", step);
        end
        ticks(112);
        total++;
        if (step !== 4'd15) begin
            bad++;
            $display("FAIL tempo_step15: got step=%0d required 15", step);
        end
        tick();
        total++;
        if (step !== 4'd15) begin
            bad++;
            $display("FAIL tempo_step15_hold: got step=%0d required 15", step);
        end
        ticks(6);
        tick();
        total++;
        if (step !== 4'd0) begin
            bad++;
            $display("FAIL tempo_wrap: got step=%0d required 0", step);
        end
    endtask

    task automatic test_pitch();
        int win1;
        int low;
        int all_ones;
        logic [3:0] pbits;
        ticks(7);
        enable = 1'b0;
        cyc(1);
        enable = 1'b1;
        tick();
        total++;
        if (step !== 4'd1 || dut.r_amp !== 8'd255 || dut.r_phase !== 16'h0000) begin
            bad++;
            $display("FAIL pitch_trigger: got step=%0d amp=%0d phase=%h required 1/255/0000", step, dut.r_amp, dut.r_phase);
        end
        win1 = 0;
        low = 0;
        all_ones = 0;
        pbits = 4'b0;
        for (int k = 1; k <= 512; k++) begin
            cyc(1);
            if (k >= 33 && k <= 64) win1 += int'(audio);
            if ((((k - 1) >> 5) & 1) == 0) low += int'(audio);
            all_ones += int'(audio);
            if (k == 31) pbits[0] = dut.r_phase[15];
            if (k == 32) pbits[1] = dut.r_phase[15];
            if (k == 63) pbits[2] = dut.r_phase[15];
            if (k == 64) pbits[3] = dut.r_phase[15];
        end
        total++;
        if (pbits !== 4'b0110) begin
            bad++;
            $display("FAIL pitch_period: got phase15 at 31/32/63/64=%b required 0110", {pbits[0], pbits[1], pbits[2], pbits[3]});
        end
        total++;
        if (low !== 0) begin
            bad++;
            $display("FAIL pitch_low_silent: got %0d ones required 0", low);
        end
        total++;
        if (win1 !== 31) begin
            bad++;
            $display("FAIL dac_first_window: got %0d ones required 31", win1);
        end
        total++;
        if (all_ones !== 255) begin
            bad++;
            $display("FAIL dac_density_255: got %0d ones required 255", all_ones);
        end
    endtask

    task automatic test_envelope();
        int ones;
        tick();
        total++;
        if (dut.r_amp !== 8'd239 || step !== 4'd1) begin
            bad++;
            $display("FAIL env_one_decay: got amp=%0d step=%0d required 239/1", dut.r_amp, step);
        end
        ones = 0;
        for (int i = 0; i < 512; i++) begin
            cyc(1);
            ones += int'(audio);
        end
        total++;
        if (ones !== 239) begin
            bad++;
            $display("FAIL dac_density_239: got %0d ones required 239", ones);
        end
        ticks(6);
        total++;
        if (dut.r_amp !== 8'd143 || note_on !== 1'b1 || step !== 4'd1) begin
            bad++;
            $display("FAIL env_seven_decays: got amp=%0d note_on=%b step=%0d required 143/1/1", dut.r_amp, note_on, step);
        end
    endtask

    task automatic test_simultaneous();
        tick();
        total++;
        if (step !== 4'd2 || dut.r_amp !== 8'd255 || dut.r_phase !== 16'h0000) begin
            bad++;
            $display("FAIL retrigger_priority: got step=%0d amp=%0d phase=%h required 2/255/0000", step, dut.r_amp, dut.r_phase);
        end
    endtask

    task automatic test_rest();
        int ones;
        ticks(16);
        ticks(7);
        tick();
        total++;
        if (step !== 4'd5 || dut.r_amp !== 8'd0) begin
            bad++;
            $display("FAIL rest_entry: got step=%0d amp=%0d required 5/0", step, dut.r_amp);
        end
        cyc(1);
        total++;
        if (note_on !== 1'b0) begin
            bad++;
            $display("FAIL rest_note_on: got %b required 0", note_on);
        end
        ones = int'(audio);
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            ones += int'(audio);
        end
        total++;
        if (ones !== 0) begin
            bad++;
            $display("FAIL rest_silent: got %0d ones required 0", ones);
        end
    endtask

    task automatic test_disable();
        bit found;
        int ones;
        logic [15:0] held_phase;
        ticks(7);
        tick();
        tick();
        total++;
        if (step !== 4'd6 || dut.r_amp !== 8'd239) begin
            bad++;
            $display("FAIL dis_setup: got step=%0d amp=%0d required 6/239", step, dut.r_amp);
        end
        wait_audio_high(found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL dis_wait_audio: got no audio pulse in 200 cycles required one");
        end
        enable = 1'b0;
        held_phase = dut.r_phase;
        cyc(1);
        total++;
        if (audio !== 1'b0) begin
            bad++;
            $display("FAIL dis_audio_off: got %b required 0", audio);
        end
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ones += int'(audio);
            cyc(2);
            ones += int'(audio);
        end
        total++;
        if (step !== 4'd6 || dut.r_amp !== 8'd239 || dut.r_phase !== held_phase || ones !== 0) begin
            bad++;
            $display("FAIL dis_hold: got step=%0d amp=%0d phase=%h ones=%0d required 6/239/%h/0", step, dut.r_amp, dut.r_phase, ones, held_phase);
        end
        enable = 1'b1;
        ticks(6);
        total++;
        if (step !== 4'd6 || dut.r_amp !== 8'd143) begin
            bad++;
            $display("FAIL dis_resume: got step=%0d amp=%0d required 6/143", step, dut.r_amp);
        end
        tick();
        total++;
        if (step !== 4'd7 || dut.r_amp !== 8'd255) begin
            bad++;
            $display("FAIL dis_resume_advance: got step=%0d amp=%0d required 7/255", step, dut.r_amp);
        end
    endtask

    task automatic test_reset_midrun();
        bit found;
        int ones;
        wait_audio_high(found);
        total++;
        if (!found || note_on !== 1'b1) begin
            bad++;
            $display("FAIL midrun_setup: got audio_seen=%b note_on=%b required 1/1", found, note_on);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (audio !== 1'b0 || step !== 4'd0 || note_on !== 1'b0 || dut.r_amp !== 8'd0) begin
            bad++;
            $display("FAIL midrun_reset: got audio=%b step=%0d note_on=%b amp=%0d required 0/0/0/0", audio, step, note_on, dut.r_amp);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            ones += int'(audio);
        end
        total++;
        if (ones !== 0 || step !== 4'd0) begin
            bad++;
            $display("FAIL midrun_step0_silent: got ones=%0d step=%0d required 0/0", ones, step);
        end
    endtask

    initial begin
        test_reset();
        test_tempo();
        test_pitch();
        test_envelope();
        test_simultaneous();
        test_rest();
        test_disable();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
